// File: rtl/ctrl_io_cfg_pkg.sv
// Shared types and constants for the ctrl_IO configuration loader.
// Field index constants locate the mux-select groups inside the ConfigBits payload.
package ctrl_io_cfg_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOAD   = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } cfg_state_t;

  localparam int         DEF_SYNC_W    = 8;
  localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;

  localparam int TO_W_SEL_LSB   = 0;
  localparam int A_I0_T_SEL_LSB = 8;
  localparam int A_I0_T_SEL_W   = 3;
  localparam int A_T_SEL        = 11;

endpackage

// File: rtl/ctrl_io_cfg_sync_det.sv
// Sliding-window sync-word matcher; match is combinational on the bit being shifted in.
// Latency 0 (match flags the accepting edge); no backpressure, shifts only when shift_en.
module ctrl_io_cfg_sync_det
  import ctrl_io_cfg_pkg::*;
#(
  parameter int                SYNC_W    = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD = DEF_SYNC_WORD
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_en,
  input  logic bit_in,
  output logic match
);

  logic [SYNC_W-1:0] window;
  logic [SYNC_W-1:0] window_nxt;

  assign window_nxt = (window << 1) | {{(SYNC_W-1){1'b0}}, bit_in};
  assign match      = shift_en && (window_nxt == SYNC_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
    end else if (clr) begin
      window <= '0;
    end else if (shift_en) begin
      window <= window_nxt;
    end
  end

endmodule

// File: rtl/ctrl_io_cfg_loader.sv
// Serial config loader: sync hunt, payload shift, even-parity check, atomic commit (opt. CTRL_IO_CFG_READBACK_EN).
// Commit one edge after the parity bit; cfg_ready drops only in COMMIT and during RST.
module ctrl_io_cfg_loader
  import ctrl_io_cfg_pkg::*;
#(
  parameter int                NoConfigBits = 12,
  parameter int                SYNC_W       = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD    = DEF_SYNC_WORD
) (
  input  logic                    UserCLK,
  input  logic                    RST,
  input  logic                    cfg_valid,
  input  logic                    cfg_bit,
  output logic                    cfg_ready,
  output logic                    cfg_done,
  output logic                    cfg_err,
  output logic [NoConfigBits-1:0] ConfigBits,
  output logic [NoConfigBits-1:0] ConfigBits_N
`ifdef CTRL_IO_CFG_READBACK_EN
  ,
  output logic                    cfg_rb_bit
`endif
);

  localparam int CNT_W = $clog2(NoConfigBits);

  cfg_state_t              state;
  logic [NoConfigBits-1:0] shadow;
  logic [CNT_W-1:0]        cnt;
  logic                    accept;
  logic                    sync_match;

  assign cfg_ready = !RST && (state != COMMIT);
  assign accept    = cfg_valid && cfg_ready;

  // Window is held clear outside HUNT, so every hunt starts from SYNC_W fresh bits.
  ctrl_io_cfg_sync_det #(
    .SYNC_W    (SYNC_W),
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_det (
    .clk      (UserCLK),
    .rst      (RST),
    .clr      (state != HUNT),
    .shift_en (accept && (state == HUNT)),
    .bit_in   (cfg_bit),
    .match    (sync_match)
  );

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      state        <= HUNT;
      shadow       <= '0;
      cnt          <= '0;
      cfg_done     <= 1'b0;
      cfg_err      <= 1'b0;
      ConfigBits   <= '0;
      ConfigBits_N <= '1;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        HUNT: begin
          if (accept && sync_match) begin
            state   <= LOAD;
            cnt     <= '0;
            cfg_err <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            shadow <= {shadow[NoConfigBits-2:0], cfg_bit};
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(NoConfigBits - 1)) begin
              state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (accept) begin
            if (^{shadow, cfg_bit}) begin
              cfg_err <= 1'b1;
              state   <= HUNT;
            end else begin
              state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          // Both polarities update on one edge so the mux selects never see a mixed word.
          ConfigBits   <= shadow;
          ConfigBits_N <= ~shadow;
          cfg_done     <= 1'b1;
          state        <= HUNT;
        end
        default: state <= HUNT;
      endcase
    end
  end

`ifdef CTRL_IO_CFG_READBACK_EN
  logic [NoConfigBits-1:0] rb;

  assign cfg_rb_bit = rb[NoConfigBits-1];

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      rb <= '0;
    end else if (state == COMMIT) begin
      rb <= ConfigBits;
    end else if ((state == HUNT) && accept) begin
      rb <= rb << 1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_io_cfg_loader.sv
// Self-checking bench for ctrl_io_cfg_loader: directed frames plus randomized streams vs a frame-parsing model.
module tb_ctrl_io_cfg_loader;

  logic        UserCLK = 1'b0;
  logic        RST;
  logic        cfg_valid;
  logic        cfg_bit;
  logic        cfg_ready;
  logic        cfg_done;
  logic        cfg_err;
  logic [11:0] ConfigBits;
  logic [11:0] ConfigBits_N;
`ifdef CTRL_IO_CFG_READBACK_EN
  logic        cfg_rb_bit;
`endif

  ctrl_io_cfg_loader dut (
    .UserCLK      (UserCLK),
    .RST          (RST),
    .cfg_valid    (cfg_valid),
    .cfg_bit      (cfg_bit),
    .cfg_ready    (cfg_ready),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .ConfigBits   (ConfigBits),
    .ConfigBits_N (ConfigBits_N)
`ifdef CTRL_IO_CFG_READBACK_EN
    ,
    .cfg_rb_bit   (cfg_rb_bit)
`endif
  );

  always #5 UserCLK = ~UserCLK;

  int          total = 0;
  int          bad   = 0;
  bit          stream[$];
  int          cyc, done_cnt, rdy_low, done_at, inv_bad;
  logic [11:0] cfg_before_done;
  logic [11:0] m_cfg;
  bit          m_err;
  int          m_commits;

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) stream.push_back(b[i]);
  endtask

  task automatic push_frame(input logic [11:0] p, input bit good);
    int ones;
    ones = 0;
    push_byte(8'hA5);
    for (int i = 11; i >= 0; i--) begin
      stream.push_back(p[i]);
      ones += int'(p[i]);
    end
    stream.push_back(good ? bit'(ones % 2) : bit'(1 - ones % 2));
  endtask

  // Frame-level parser: hunt for the last 8 bits == A5, then 12 payload bits and a parity bit.
  task automatic run_model();
    int i, win, n, pv, ones;
    bit par;
    i = 0;
    m_commits = 0;
    while (i < stream.size()) begin
      win = 0; n = 0;
      while (i < stream.size() && !(n >= 8 && win == 165)) begin
        win = (win * 2 + int'(stream[i])) % 256;
        n++; i++;
      end
      if (!(n >= 8 && win == 165)) break;
      m_err = 1'b0;
      if (stream.size() - i < 13) break;
      pv = 0; ones = 0;
      for (int k = 0; k < 12; k++) begin
        pv = pv * 2 + int'(stream[i]);
        ones += int'(stream[i]);
        i++;
      end
      par = stream[i];
      i++;
      if ((ones + int'(par)) % 2 == 1) m_err = 1'b1;
      else begin
        m_cfg = 12'(pv);
        m_commits++;
      end
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; cfg_valid = 1'b0; cfg_bit = 1'b0;
    repeat (2) @(negedge UserCLK);
    RST = 1'b0;
    m_cfg = 12'h000; m_err = 1'b0;
  endtask

  task automatic observe();
    cyc++;
    if (cfg_done) begin
      done_cnt++;
      if (done_at == 0) done_at = cyc;
    end else if (done_at == 0) begin
      cfg_before_done = ConfigBits;
    end
    if (!cfg_ready) rdy_low++;
    if (ConfigBits_N !== ~ConfigBits) inv_bad++;
  endtask

  task automatic drive(input bit gaps);
    int idx;
    bit v;
    idx = 0; cyc = 0; done_cnt = 0; rdy_low = 0; done_at = 0; inv_bad = 0;
    cfg_before_done = ConfigBits;
    while (idx < stream.size() && cyc < 5000) begin
      @(negedge UserCLK);
      observe();
      v = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
      cfg_valid = v;
      cfg_bit   = stream[idx];
      if (v && cfg_ready) idx++;
    end
    if (idx < stream.size()) begin
      total++; bad++;
      $display("FAIL drive_timeout: accepted %0d bits, required %0d", idx, stream.size());
    end
    repeat (4) begin
      @(negedge UserCLK);
      observe();
      cfg_valid = 1'b0;
    end
    total++;
    if (inv_bad != 0) begin bad++; $display("FAIL invariant_n: %0d cycles with ConfigBits_N != ~ConfigBits, required 0", inv_bad); end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge UserCLK);
    total++; if (ConfigBits !== 12'h000)   begin bad++; $display("FAIL reset_cfg: got %h want 000", ConfigBits); end
    total++; if (ConfigBits_N !== 12'hFFF) begin bad++; $display("FAIL reset_cfg_n: got %h want fff", ConfigBits_N); end
    total++; if (cfg_ready !== 1'b1)       begin bad++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
    total++; if (cfg_done !== 1'b0)        begin bad++; $display("FAIL reset_done: got %b want 0", cfg_done); end
    total++; if (cfg_err !== 1'b0)         begin bad++; $display("FAIL reset_err: got %b want 0", cfg_err); end
  endtask

  task automatic test_single_frame();
    do_reset();
    stream.delete();
    push_frame(12'h80F, 1'b1);
    run_model();
    drive(1'b0);
    total++; if (ConfigBits !== 12'h80F)      begin bad++; $display("FAIL single_cfg: got %h want 80f", ConfigBits); end
    total++; if (ConfigBits_N !== 12'h7F0)    begin bad++; $display("FAIL single_cfg_n: got %h want 7f0", ConfigBits_N); end
    total++; if (done_cnt != 1)               begin bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    total++; if (done_at - 1 != 22)           begin bad++; $display("FAIL single_latency: got %0d edges want 22", done_at - 1); end
    total++; if (cfg_before_done !== 12'h000) begin bad++; $display("FAIL single_no_early: got %h want 000", cfg_before_done); end
    total++; if (rdy_low != 1)                begin bad++; $display("FAIL single_ready_low: got %0d want 1", rdy_low); end
    total++; if (cfg_err !== 1'b0)            begin bad++; $display("FAIL single_err: got %b want 0", cfg_err); end
  endtask

  task automatic test_bad_parity();
    do_reset();
    stream.delete();
    push_frame(12'h80F, 1'b1);
    push_frame(12'h80F, 1'b0);
    push_byte(8'h00);
    run_model();
    drive(1'b0);
    total++; if (ConfigBits !== m_cfg)   begin bad++; $display("FAIL badpar_cfg: got %h want %h", ConfigBits, m_cfg); end
    total++; if (cfg_err !== m_err)      begin bad++; $display("FAIL badpar_err: got %b want %b", cfg_err, m_err); end
    total++; if (done_cnt != m_commits)  begin bad++; $display("FAIL badpar_done: got %0d want %0d", done_cnt, m_commits); end
    stream.delete();
    push_frame(12'h5A3, 1'b1);
    run_model();
    drive(1'b0);
    total++; if (cfg_err !== 1'b0)       begin bad++; $display("FAIL badpar_clear_err: got %b want 0", cfg_err); end
    total++; if (ConfigBits !== 12'h5A3) begin bad++; $display("FAIL badpar_next_cfg: got %h want 5a3", ConfigBits); end
  endtask

  task automatic test_gaps();
    do_reset();
    stream.delete();
    push_frame(12'h5A3, 1'b1);
    run_model();
    drive(1'b1);
    total++; if (ConfigBits !== 12'h5A3)   begin bad++; $display("FAIL gaps_cfg: got %h want 5a3", ConfigBits); end
    total++; if (ConfigBits_N !== 12'hA5C) begin bad++; $display("FAIL gaps_cfg_n: got %h want a5c", ConfigBits_N); end
    total++; if (done_cnt != 1)            begin bad++; $display("FAIL gaps_done: got %0d want 1", done_cnt); end
    total++; if (rdy_low != 1)             begin bad++; $display("FAIL gaps_ready_low: got %0d want 1", rdy_low); end
  endtask

  task automatic test_noise();
    logic [8:0] noise;
    do_reset();
    stream.delete();
    noise = 9'b1010_0100_1;
    for (int i = 8; i >= 0; i--) stream.push_back(noise[i]);
    push_frame(12'hA5C, 1'b1);
    run_model();
    drive(1'b0);
    total++; if (ConfigBits !== 12'hA5C) begin bad++; $display("FAIL noise_cfg: got %h want a5c", ConfigBits); end
    total++; if (ConfigBits !== m_cfg)   begin bad++; $display("FAIL noise_model: got %h want %h", ConfigBits, m_cfg); end
    total++; if (done_cnt != 1)          begin bad++; $display("FAIL noise_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    stream.delete();
    push_frame(12'h80F, 1'b1);
    drive(1'b0);
    stream.delete();
    push_byte(8'hA5);
    for (int i = 0; i < 6; i++) stream.push_back(1'b1);
    drive(1'b0);
    @(negedge UserCLK);
    RST = 1'b1;
    #1;
    total++; if (ConfigBits !== 12'h000)   begin bad++; $display("FAIL rstmid_cfg: got %h want 000", ConfigBits); end
    total++; if (ConfigBits_N !== 12'hFFF) begin bad++; $display("FAIL rstmid_cfg_n: got %h want fff", ConfigBits_N); end
    total++; if (cfg_ready !== 1'b0)       begin bad++; $display("FAIL rstmid_ready: got %b want 0", cfg_ready); end
    @(negedge UserCLK);
    RST = 1'b0;
    m_cfg = 12'h000; m_err = 1'b0;
    stream.delete();
    push_frame(12'h123, 1'b1);
    drive(1'b0);
    total++; if (ConfigBits !== 12'h123)   begin bad++; $display("FAIL rstmid_after: got %h want 123", ConfigBits); end
  endtask

  task automatic test_random();
    int nf, nn;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      stream.delete();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        nn = $urandom_range(0, 6);
        for (int b = 0; b < nn; b++) stream.push_back(bit'($urandom_range(0, 1)));
        push_frame(12'($urandom), $urandom_range(0, 3) != 0);
      end
      run_model();
      drive(bit'($urandom_range(0, 1)));
      total++; if (ConfigBits !== m_cfg)    begin bad++; $display("FAIL rand%0d_cfg: got %h want %h", it, ConfigBits, m_cfg); end
      total++; if (ConfigBits_N !== ~m_cfg) begin bad++; $display("FAIL rand%0d_cfg_n: got %h want %h", it, ConfigBits_N, ~m_cfg); end
      total++; if (cfg_err !== m_err)       begin bad++; $display("FAIL rand%0d_err: got %b want %b", it, cfg_err, m_err); end
      total++; if (done_cnt != m_commits)   begin bad++; $display("FAIL rand%0d_done: got %0d want %0d", it, done_cnt, m_commits); end
      total++; if (rdy_low != m_commits)    begin bad++; $display("FAIL rand%0d_ready_low: got %0d want %0d", it, rdy_low, m_commits); end
    end
  endtask

`ifdef CTRL_IO_CFG_READBACK_EN
  task automatic test_readback();
    logic [11:0] got;
    do_reset();
    stream.delete();
    push_frame(12'h80F, 1'b1);
    push_frame(12'h123, 1'b1);
    drive(1'b0);
    got = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge UserCLK);
      got = {got[10:0], cfg_rb_bit};
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
    end
    @(negedge UserCLK);
    cfg_valid = 1'b0;
    total++; if (got !== 12'h80F) begin bad++; $display("FAIL readback: got %h want 80f", got); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_bad_parity();
    test_gaps();
    test_noise();
    test_reset_mid_frame();
    test_random();
`ifdef CTRL_IO_CFG_READBACK_EN
    test_readback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
